// File: rtl/sub16_serial.sv
// Digit-serial 16-bit subtractor, Z = X - Y, one SLICE_W slice per clock.
// Start/busy/done handshake; result and flags held until the next done.
module sub16_serial #(
    parameter int SLICE_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    output logic        busy,
    output logic        done,
    output logic [15:0] Z,
    output logic        Borrow,
    output logic        Parity,
    output logic        Overflow,
    output logic        Zero,
    output logic        Sign
);

    localparam int NSLICE = 16 / SLICE_W;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0]        xr, yr, acc, acc_nxt;
    logic               c;
    logic [KW-1:0]      k;
    logic [3:0]         base;
    logic               last;
    logic [SLICE_W-1:0] xs, ys;
    logic [SLICE_W:0]   sum;

    assign last = (k == KLAST);
    assign base = 4'(k) * 4'(SLICE_W);
    assign xs   = xr[base +: SLICE_W];
    assign ys   = yr[base +: SLICE_W];
    assign sum  = {1'b0, xs} + {1'b0, ys} + {{SLICE_W{1'b0}}, c};

    always_comb begin
        acc_nxt = acc;
        acc_nxt[base +: SLICE_W] = sum[SLICE_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // yr holds ~Y, so yr[15] is the inverted subtrahend sign
    always_ff @(posedge clk) begin
        if (rst) begin
            xr       <= '0;
            yr       <= '0;
            acc      <= '0;
            c        <= 1'b0;
            k        <= '0;
            Z        <= '0;
            Borrow   <= 1'b0;
            Parity   <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Sign     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        xr  <= X;
                        yr  <= ~Y;
                        c   <= 1'b1;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    c   <= sum[SLICE_W];
                    if (!last) begin
                        k <= k + 1'b1;
                    end else begin
                        Z        <= acc_nxt;
                        Borrow   <= ~sum[SLICE_W];
                        Sign     <= acc_nxt[15];
                        Zero     <= (acc_nxt == 16'h0000);
                        Parity   <= ~^acc_nxt;
                        Overflow <= (xr[15] ^ ~yr[15])
                                  & (acc_nxt[15] ^ xr[15]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub16_serial.sv
// Bench for sub16_serial at SLICE_W = 4, 1 and 16 against a
// cycle-count model of the handshake plus X - Y arithmetic.
module tb_sub16_serial;

    localparam int NS [3] = '{4, 16, 1};

    logic        clk;
    logic        rst;
    logic        st   [3];
    logic [15:0] xa   [3];
    logic [15:0] ya   [3];
    logic        busy [3];
    logic        done [3];
    logic [15:0] z    [3];
    logic        bo   [3];
    logic        pa   [3];
    logic        ov   [3];
    logic        ze   [3];
    logic        sg   [3];

    int ncmp = 0;
    int nbad = 0;
    bit chk_en = 0;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 0) ? 4 : (g == 1) ? 1 : 16;
        sub16_serial #(.SLICE_W(W)) dut (
            .clk     (clk),
            .rst     (rst),
            .start   (st[g]),
            .X       (xa[g]),
            .Y       (ya[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .Z       (z[g]),
            .Borrow  (bo[g]),
            .Parity  (pa[g]),
            .Overflow(ov[g]),
            .Zero    (ze[g]),
            .Sign    (sg[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Z, Borrow, Parity, Overflow, Zero, Sign} from plain arithmetic
    function automatic logic [20:0] ref_of(input logic [15:0] x, input logic [15:0] y);
        int sx, sy, d;
        logic [15:0] r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        d  = sx - sy;
        r  = x - y;
        return {r, x < y, ($countones(r) % 2) == 0,
                (d > 32767) || (d < -32768), r == 16'h0000, r[15]};
    endfunction

    function automatic logic [20:0] dut_res(input int i);
        return {z[i], bo[i], pa[i], ov[i], ze[i], sg[i]};
    endfunction

    int          mcnt  [3] = '{0, 0, 0};
    logic [20:0] mres  [3] = '{'0, '0, '0};
    logic [20:0] mpend [3] = '{'0, '0, '0};

    // cycles left of busy; done is the last busy cycle
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mcnt[i] <= 0;
                mres[i] <= '0;
            end else if (mcnt[i] > 0) begin
                mcnt[i] <= mcnt[i] - 1;
                if (mcnt[i] == 2) mres[i] <= mpend[i];
            end else if (st[i]) begin
                mcnt[i]  <= NS[i] + 1;
                mpend[i] <= ref_of(xa[i], ya[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [22:0] got, exp;
                got = {busy[i], done[i], dut_res(i)};
                exp = {mcnt[i] > 0, mcnt[i] == 1, mres[i]};
                ncmp++;
                if (got !== exp) begin
                    nbad++;
                    $display("FAIL cycle inst%0d t=%0t: got %h want %h",
                             i, $time, got, exp);
                end
            end
        end
    end

    task automatic chk(input int i, input string nm,
                       input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s inst%0d: got %h want %h", nm, i, got, exp);
        end
    endtask

    task automatic start_op(input int i, input logic [15:0] x, input logic [15:0] y);
        st[i] = 1'b1;
        xa[i] = x;
        ya[i] = y;
        @(negedge clk);
        st[i] = 1'b0;
        xa[i] = 16'($urandom);
        ya[i] = 16'($urandom);
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = 1;
        while (!done[i] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input int i, input string nm, input logic [15:0] x,
                          input logic [15:0] y, input logic [20:0] exp);
        int cyc;
        start_op(i, x, y);
        wait_done(i, cyc);
        chk(i, {nm, "_lat"}, cyc, NS[i] + 1);
        chk(i, nm, 32'(dut_res(i)), 32'(exp));
        @(negedge clk);
    endtask

    task automatic chk_zero(input int i, input string nm);
        chk(i, nm, {busy[i], done[i], dut_res(i)}, 32'd0);
    endtask

    task automatic run_set(input int i);
        int nb, nd, cyc;
        logic [15:0] zf;
        run_op(i, "sub_5_3",  16'h0005, 16'h0003, {16'h0002, 5'b00000});
        run_op(i, "sub_3_5",  16'h0003, 16'h0005, {16'hFFFE, 5'b10001});
        run_op(i, "ovf_neg",  16'h8000, 16'h0001, {16'h7FFF, 5'b00100});
        run_op(i, "ovf_pos",  16'h7FFF, 16'hFFFF, {16'h8000, 5'b10101});
        run_op(i, "zero",     16'h1234, 16'h1234, {16'h0000, 5'b01010});

        // starts during RUN and DONE are dropped; start held into IDLE is taken
        start_op(i, 16'h0010, 16'h0001);
        nb = 0;
        nd = 0;
        zf = '0;
        for (int c = 0; c < 40 && (c == 0 || busy[i]); c++) begin
            if (busy[i]) nb++;
            if (done[i]) begin
                nd++;
                zf = z[i];
            end
            st[i] = (c == 0) || done[i];
            xa[i] = 16'hFFFF;
            ya[i] = 16'h0000;
            @(negedge clk);
        end
        chk(i, "hs_busy", nb, NS[i] + 1);
        chk(i, "hs_done", nd, 1);
        chk(i, "hs_z", zf, 16'h000F);
        @(negedge clk);
        st[i] = 1'b0;
        wait_done(i, cyc);
        chk(i, "b2b_lat", cyc, NS[i] + 1);
        chk(i, "b2b_res", 32'(dut_res(i)), 32'({16'hFFFF, 5'b01001}));
        @(negedge clk);

        // reset mid-RUN
        start_op(i, 16'h4321, 16'h0123);
        repeat ((NS[i] >= 3 ? 3 : NS[i]) - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero(i, "rst_run");
        @(negedge clk);
        chk_zero(i, "rst_run_idle");

        run_op(i, "post_rst", 16'h0100, 16'h0001, {16'h00FF, 5'b01000});

        // reset in DONE
        start_op(i, 16'h0007, 16'h0002);
        wait_done(i, cyc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero(i, "rst_done");

        // reset and start on the same edge
        rst   = 1'b1;
        st[i] = 1'b1;
        xa[i] = 16'h0009;
        ya[i] = 16'h0001;
        @(negedge clk);
        rst   = 1'b0;
        st[i] = 1'b0;
        chk_zero(i, "rst_start");
        @(negedge clk);
        chk(i, "rst_start_idle", busy[i], 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            xa[i] = '0;
            ya[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_zero(i, "reset");
        rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) run_set(i);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/sub16_serial.md
# sub16_serial

Digit-serial 16-bit two's-complement subtractor computing Z = X − Y one slice per clock, LSB slice first. It is the inverse counterpart of the team's combinational 16-bit adder and reports the same flag set, with Carry replaced by Borrow. The block sits on the datapath ALU's slow path, where area matters more than latency. Operations are exchanged through a start/busy/done handshake.

## Interface

- SLICE_W, default 4: slice width in bits. Legal values are 1, 2, 4, 8 and 16. NSLICE = 16/SLICE_W.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset; has priority over every other input.
- start  in  1  request; sampled only in IDLE.
- X  in  16  minuend; captured when start is accepted.
- Y  in  16  subtrahend; captured when start is accepted.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result and flags are valid.
- Z  out  16  difference, registered.
- Borrow  out  1  1 when unsigned X < unsigned Y.
- Parity  out  1  even parity of Z: 1 when popcount(Z) is even.
- Overflow  out  1  signed overflow of X − Y.
- Zero  out  1  1 when Z == 16'h0000.
- Sign  out  1  Z[15].

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start = 1.
  - RUN → DONE after slice NSLICE−1 completes.
  - DONE → IDLE unconditionally.
- Accept (IDLE with start = 1):
  - Latch X into xr and ~Y into yr.
  - Set the carry register c = 1, since X − Y = X + ~Y + 1.
  - Set the slice counter k = 0 and clear the result accumulator.
- RUN, each cycle:
  - {cout, s} = xr[k-slice] + yr[k-slice] + c.
  - Write s into accumulator bits [k*SLICE_W +: SLICE_W].
  - c ← cout, k ← k + 1.
  - The counter is wide enough to hold NSLICE−1 and does not wrap inside an operation.
- Entry into DONE:
  - Z ← accumulator.
  - Borrow ← ~c (final carry out inverted).
  - Sign ← Z[15].
  - Zero ← (Z == 0).
  - Parity ← ~^Z.
  - Overflow ← (X[15] ^ Y[15]) & (Z[15] ^ X[15]), using the latched operands.
- Z and all flags hold their values until the next completed operation or reset. They do not change during RUN.
- start while busy = 1 is ignored and is not queued. start asserted in DONE is also ignored.
- X and Y may change freely after the accept edge.

## Timing

- Reset values: state = IDLE; busy, done, Z, Borrow, Parity, Overflow, Zero and Sign are all 0.
  - Parity resets to 0 even though Z = 0, because flags are undefined until the first done.
- Edge sequence:
  - Accept at edge E0: busy rises after E0.
  - Slices are computed at edges E1..E_NSLICE.
  - At E_NSLICE the state enters DONE; done = 1 and the result is valid for exactly one cycle.
  - At E_NSLICE+1 the state returns to IDLE; busy and done fall.
- Latency: NSLICE + 1 cycles from accept to done (5 for the default).
- Minimum issue interval: NSLICE + 2 cycles, since the next start is accepted at the first edge in IDLE.
- rst mid-RUN or in DONE:
  - Aborts the operation immediately; no done pulse is produced.
  - Outputs return to their reset values at that edge.
- rst and start high on the same edge: reset wins and the request is dropped.

## Test plan

- X = 0x0005, Y = 0x0003 → done 5 cycles after accept. Z = 0x0002, Borrow 0, Sign 0, Zero 0, Parity 0, Overflow 0.
- X = 0x0003, Y = 0x0005 → Z = 0xFFFE, Borrow 1, Sign 1, Zero 0, Parity 0, Overflow 0.
- X = 0x8000, Y = 0x0001 → Z = 0x7FFF, Overflow 1, Borrow 0, Sign 0, Parity 0. Also X = 0x7FFF, Y = 0xFFFF → Z = 0x8000, Overflow 1, Borrow 1.
- X = 0x1234, Y = 0x1234 → Z = 0x0000, Zero 1, Parity 1, Borrow 0, Overflow 0.
- Handshake: pulse start with X = 0x0010, Y = 0x0001, then pulse start again with X = 0xFFFF, Y = 0 during RUN and during DONE.
  - Required: exactly one done with Z = 0x000F.
  - busy high for 5 cycles.
  - A back-to-back start on the first IDLE edge is accepted.
- Reset: assert rst during the 3rd RUN cycle.
  - Required: no done, all outputs 0 on the next cycle, state IDLE.
  - A following op X = 0x0100, Y = 0x0001 gives Z = 0x00FF, Parity 1.
  - Repeat the whole set with SLICE_W = 1 (latency 17) and SLICE_W = 16 (latency 2).
